// File: rtl/hicore_ifetch_mo.sv
// Multi-outstanding instruction fetch: issues ICB reads ahead, tracks them in order,
// drops responses made stale by a redirect and delivers words/exceptions to decode.
module hicore_ifetch_mo #(
    parameter int                      PC_W     = 32,
    parameter int                      DATA_W   = 32,
    parameter int                      MAX_OS   = 4,
    parameter int                      LOG_OS   = 2,
    parameter int                      OUT_DP   = 2,
    parameter logic [PC_W-1:0]         RESET_PC = 32'h8000_0000,
    parameter int                      REG_HI   = 31,
    parameter int                      REG_LO   = 16,
    parameter logic [REG_HI-REG_LO:0]  REG_BASE = 16'h8000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [PC_W-1:0]   req_addr,
    input  logic              rsp_valid,
    output logic              rsp_ready,
    input  logic [DATA_W-1:0] rsp_rdata,
    input  logic              rsp_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_instr,
    output logic [2:0]        out_excp,
    input  logic              flush,
    input  logic [PC_W-1:0]   flush_pc,
    input  logic              branch,
    input  logic [PC_W-1:0]   branch_pc
);

    localparam int OPW = (OUT_DP > 1) ? $clog2(OUT_DP) : 1;
    localparam int OCW = $clog2(OUT_DP + 1);
    localparam logic [LOG_OS+1:0] OCC_LIM = (LOG_OS+2)'(MAX_OS);
    localparam logic [LOG_OS:0]   TRK_LIM = (LOG_OS+1)'(MAX_OS);
    localparam logic [OCW-1:0]    OUT_LIM = OCW'(OUT_DP);
    localparam logic [OPW-1:0]    OPTR_TOP = OPW'(OUT_DP - 1);

    // {bus_err, region_fault, misalign}; bus_err is only known once the response returns
    function automatic logic [2:0] fault_of(input logic [PC_W-1:0] a);
        fault_of = {1'b0, (a[REG_HI:REG_LO] != REG_BASE), |a[1:0]};
    endfunction

    function automatic logic [OPW-1:0] optr_next(input logic [OPW-1:0] p);
        optr_next = (p == OPTR_TOP) ? '0 : p + OPW'(1);
    endfunction

    logic [PC_W-1:0]   pc;
    logic              halt;
    logic [LOG_OS:0]   kill_cnt;
    logic [LOG_OS:0]   trk_cnt;
    logic [LOG_OS:0]   bus_cnt;
    logic [LOG_OS-1:0] trk_wr;
    logic [LOG_OS-1:0] trk_rd;

    logic [PC_W-1:0]   trk_pc_p0   [MAX_OS];
    logic              trk_bus_p0  [MAX_OS];
    logic [2:0]        trk_excp_p0 [MAX_OS];

    logic [PC_W-1:0]   out_pc_p1    [OUT_DP];
    logic [DATA_W-1:0] out_instr_p1 [OUT_DP];
    logic [2:0]        out_excp_p1  [OUT_DP];
    logic [OPW-1:0]    out_wr;
    logic [OPW-1:0]    out_rd;
    logic [OCW-1:0]    out_cnt;
    logic              vld_p1;

    logic              redirect;
    logic [PC_W-1:0]   target;
    logic [2:0]        pc_excp;
    logic              fault;
    logic [LOG_OS+1:0] occ;
    logic              slot;
    logic              cmd_hs;
    logic              fault_push;
    logic              trk_push;
    logic              head_vld;
    logic              head_bus;
    logic              killing;
    logic              out_pop;
    logic              out_space;
    logic              rsp_hs;
    logic              rsp_drop;
    logic              head_pop;
    logic [PC_W-1:0]   wr_pc;
    logic [DATA_W-1:0] wr_instr;
    logic [2:0]        wr_excp;

    assign redirect = flush | branch;
    assign target   = flush ? flush_pc : branch_pc;
    assign pc_excp  = fault_of(pc);
    assign fault    = |pc_excp;

    // Killed responses still occupy bus slots, so they count against the budget.
    assign occ  = {1'b0, trk_cnt} + {1'b0, kill_cnt};
    assign slot = (occ < OCC_LIM);

    assign req_valid  = ~redirect & ~halt & ~fault & slot & ~rst;
    assign req_addr   = pc;
    assign cmd_hs     = req_valid & req_ready;
    assign fault_push = ~redirect & ~halt & fault & (trk_cnt < TRK_LIM) & ~rst;
    assign trk_push   = cmd_hs | fault_push;

    assign head_vld  = (trk_cnt != '0);
    assign head_bus  = trk_bus_p0[trk_rd];
    assign killing   = (kill_cnt != '0);
    assign out_pop   = vld_p1 & out_ready;
    assign out_space = (out_cnt != OUT_LIM) | out_pop;

    assign rsp_ready = ~rst & (killing | redirect | (head_vld & head_bus & out_space));
    assign rsp_hs    = rsp_valid & rsp_ready;
    assign rsp_drop  = rsp_hs & killing;

    // Exception entries leave the head without waiting for the bus.
    assign head_pop = ~redirect & head_vld & out_space &
                      (head_bus ? (rsp_hs & ~killing) : 1'b1);

    assign wr_pc    = trk_pc_p0[trk_rd];
    assign wr_instr = head_bus ? rsp_rdata : '0;
    assign wr_excp  = head_bus ? {rsp_err, 2'b00} : trk_excp_p0[trk_rd];

    // ---- stage p0: tracking FIFO storage (issued fetches / pending exceptions)
    always_ff @(posedge clk) begin
        if (trk_push) begin
            trk_pc_p0[trk_wr]   <= pc;
            trk_bus_p0[trk_wr]  <= cmd_hs;
            trk_excp_p0[trk_wr] <= cmd_hs ? 3'b000 : pc_excp;
        end
    end

    // ---- stage p1: decoder-side output FIFO storage
    always_ff @(posedge clk) begin
        if (head_pop) begin
            out_pc_p1[out_wr]    <= wr_pc;
            out_instr_p1[out_wr] <= wr_instr;
            out_excp_p1[out_wr]  <= wr_excp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            halt     <= 1'b0;
            kill_cnt <= '0;
            trk_cnt  <= '0;
            bus_cnt  <= '0;
            trk_wr   <= '0;
            trk_rd   <= '0;
            out_wr   <= '0;
            out_rd   <= '0;
            out_cnt  <= '0;
        end else if (redirect) begin
            pc       <= target;
            halt     <= 1'b0;
            kill_cnt <= kill_cnt + bus_cnt - (LOG_OS+1)'(rsp_hs);
            trk_cnt  <= '0;
            bus_cnt  <= '0;
            trk_wr   <= '0;
            trk_rd   <= '0;
            out_wr   <= '0;
            out_rd   <= '0;
            out_cnt  <= '0;
        end else begin
            if (cmd_hs)
                pc <= pc + PC_W'(4);
            if (fault_push)
                halt <= 1'b1;
            if (rsp_drop)
                kill_cnt <= kill_cnt - (LOG_OS+1)'(1);
            if (trk_push)
                trk_wr <= trk_wr + LOG_OS'(1);
            if (head_pop)
                trk_rd <= trk_rd + LOG_OS'(1);
            trk_cnt <= trk_cnt + (LOG_OS+1)'(trk_push) - (LOG_OS+1)'(head_pop);
            bus_cnt <= bus_cnt + (LOG_OS+1)'(cmd_hs) - (LOG_OS+1)'(head_pop & head_bus);
            if (head_pop)
                out_wr <= optr_next(out_wr);
            if (out_pop)
                out_rd <= optr_next(out_rd);
            out_cnt <= out_cnt + OCW'(head_pop) - OCW'(out_pop);
        end
    end

    assign vld_p1    = (out_cnt != '0);
    assign out_valid = vld_p1;
    assign out_pc    = vld_p1 ? out_pc_p1[out_rd]    : '0;
    assign out_instr = vld_p1 ? out_instr_p1[out_rd] : '0;
    assign out_excp  = vld_p1 ? out_excp_p1[out_rd]  : '0;

endmodule

// File: tb/tb_hicore_ifetch_mo.sv
// Directed bench for hicore_ifetch_mo with an in-order, 1-cycle-latency icache model.
module tb_hicore_ifetch_mo;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_instr;
    logic [2:0]  out_excp;
    logic        flush, branch;
    logic [31:0] flush_pc, branch_pc;

    hicore_ifetch_mo dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .out_excp(out_excp),
        .flush(flush), .flush_pc(flush_pc), .branch(branch), .branch_pc(branch_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] a; int c; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; logic [2:0] excp; int c; } out_t;

    req_t        req_log[$];
    out_t        out_log[$];
    logic [31:0] q[$];
    logic        stall;
    logic [31:0] err_addr;
    int          cyc_n = 0;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_pc;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'h3C3C_A5A5;
    endfunction

    function automatic req_t req_at(input int i);
        req_t r;
        r.a = 'x; r.c = -1;
        if (i < req_log.size()) r = req_log[i];
        return r;
    endfunction

    function automatic out_t out_at(input int i);
        out_t o;
        o.pc = 'x; o.instr = 'x; o.excp = 'x; o.c = -1;
        if (i < out_log.size()) o = out_log[i];
        return o;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_rsp();
        if (q.size() > 0 && !stall) begin
            rsp_valid = 1'b1;
            rsp_rdata = data_of(q[0]);
            rsp_err   = (q[0] == err_addr);
        end else begin
            rsp_valid = 1'b0;
            rsp_rdata = '0;
            rsp_err   = 1'b0;
        end
    endtask

    task automatic clear_logs();
        req_log.delete();
        out_log.delete();
    endtask

    task automatic cyc();
        logic        hs_cmd, hs_rsp;
        logic [31:0] a, tmp;
        req_t        r;
        out_t        o;
        #1;
        hs_cmd = req_valid && req_ready;
        a      = req_addr;
        hs_rsp = rsp_valid && rsp_ready;
        if (rsp_valid && !rst) begin
            checks++;
            assert (!(dut.trk_cnt == '0 && dut.kill_cnt == '0)) else begin
                errors++;
                $error("FAIL orphan_rsp: observed response with nothing tracked, expected none");
            end
        end
        if (out_valid && out_ready) begin
            o.pc = out_pc; o.instr = out_instr; o.excp = out_excp; o.c = cyc_n;
            out_log.push_back(o);
        end
        if (hs_cmd) begin
            r.a = a; r.c = cyc_n;
            req_log.push_back(r);
        end
        @(posedge clk);
        #1;
        cyc_n++;
        if (rst) begin
            q.delete();
        end else begin
            if (hs_rsp) tmp = q.pop_front();
            if (hs_cmd) q.push_back(a);
        end
        drive_rsp();
        #1;
    endtask

    initial begin
        rst = 1'b1; req_ready = 1'b1; out_ready = 1'b1;
        flush = 1'b0; branch = 1'b0; flush_pc = '0; branch_pc = '0;
        stall = 1'b0; err_addr = 32'hFFFF_FFFF;
        drive_rsp();
        cyc(); cyc();
        chk("rst_req_valid", 64'(req_valid), 64'd0);
        chk("rst_rsp_ready", 64'(rsp_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_pc",    64'(out_pc),    64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
        chk("rst_out_excp",  64'(out_excp),  64'd0);

        // streaming from reset
        rst = 1'b0;
        clear_logs();
        repeat (6) cyc();
        chk("stream_req0", 64'(req_at(0).a), 64'h8000_0000);
        chk("stream_req1", 64'(req_at(1).a), 64'h8000_0004);
        chk("stream_req2", 64'(req_at(2).a), 64'h8000_0008);
        chk("stream_out0", 64'(out_at(0).pc), 64'h8000_0000);
        chk("stream_out1", 64'(out_at(1).pc), 64'h8000_0004);
        chk("stream_out2", 64'(out_at(2).pc), 64'h8000_0008);
        chk("stream_instr0", 64'(out_at(0).instr), 64'(data_of(32'h8000_0000)));
        chk("stream_excp0", 64'(out_at(0).excp), 64'd0);
        chk("stream_excp2", 64'(out_at(2).excp), 64'd0);
        chk("stream_latency", 64'(out_at(0).c - req_at(0).c), 64'd2);
        chk("stream_rate", 64'(out_at(3).c - out_at(0).c), 64'd3);

        // drain, then stall responses: at most four fetches in flight
        req_ready = 1'b0;
        repeat (4) cyc();
        stall = 1'b1; drive_rsp();
        req_ready = 1'b1;
        clear_logs();
        repeat (10) cyc();
        chk("stall_hs_count", 64'(req_log.size()), 64'd4);
        chk("stall_req0", 64'(req_at(0).a), 64'h8000_0018);
        chk("stall_req3", 64'(req_at(3).a), 64'h8000_0024);
        chk("stall_req_valid", 64'(req_valid), 64'd0);
        chk("stall_no_out", 64'(out_log.size()), 64'd0);
        stall = 1'b0; drive_rsp();
        clear_logs();
        repeat (8) cyc();
        chk("drain_out0", 64'(out_at(0).pc), 64'h8000_0018);
        chk("drain_out1", 64'(out_at(1).pc), 64'h8000_001C);
        chk("drain_out3", 64'(out_at(3).pc), 64'h8000_0024);
        chk("drain_instr3", 64'(out_at(3).instr), 64'(data_of(32'h8000_0024)));
        chk("drain_resume", 64'(req_at(0).a), 64'h8000_0028);

        // branch with three fetches in flight
        req_ready = 1'b0;
        repeat (6) cyc();
        stall = 1'b1; drive_rsp();
        req_ready = 1'b1;
        clear_logs();
        repeat (3) cyc();
        chk("br_setup_hs", 64'(req_log.size()), 64'd3);
        branch = 1'b1; branch_pc = 32'h8000_0100;
        #1;
        chk("br_rsp_ready", 64'(rsp_ready), 64'd1);
        chk("br_req_valid", 64'(req_valid), 64'd0);
        cyc();
        branch = 1'b0;
        chk("br_kill_cnt", 64'(dut.kill_cnt), 64'd3);
        stall = 1'b0; drive_rsp();
        clear_logs();
        repeat (4) cyc();
        chk("br_dropped_no_out", 64'(out_log.size()), 64'd0);
        chk("br_kill_done", 64'(dut.kill_cnt), 64'd0);
        chk("br_first_req", 64'(req_at(0).a), 64'h8000_0100);
        repeat (4) cyc();
        chk("br_out0", 64'(out_at(0).pc), 64'h8000_0100);
        chk("br_out1", 64'(out_at(1).pc), 64'h8000_0104);

        // flush wins over a simultaneous branch
        flush = 1'b1; flush_pc = 32'h8000_0200;
        branch = 1'b1; branch_pc = 32'h8000_0300;
        cyc();
        flush = 1'b0; branch = 1'b0;
        chk("fl_out_emptied", 64'(out_valid), 64'd0);
        clear_logs();
        cyc();
        chk("fl_req0", 64'(req_at(0).a), 64'h8000_0200);
        repeat (7) cyc();
        chk("fl_out0", 64'(out_at(0).pc), 64'h8000_0200);

        // misaligned target: exception entry, fetch halts
        branch = 1'b1; branch_pc = 32'h8000_0102;
        cyc();
        branch = 1'b0;
        clear_logs();
        repeat (6) cyc();
        chk("mis_no_req", 64'(req_log.size()), 64'd0);
        chk("mis_out_cnt", 64'(out_log.size()), 64'd1);
        chk("mis_out_pc", 64'(out_at(0).pc), 64'h8000_0102);
        chk("mis_out_excp", 64'(out_at(0).excp), 64'b001);
        chk("mis_out_instr", 64'(out_at(0).instr), 64'd0);
        chk("mis_halted", 64'(req_valid), 64'd0);
        flush = 1'b1; flush_pc = 32'h8000_0000;
        cyc();
        flush = 1'b0;
        clear_logs();
        repeat (3) cyc();
        chk("resume_req0", 64'(req_at(0).a), 64'h8000_0000);
        chk("resume_req1", 64'(req_at(1).a), 64'h8000_0004);

        // target outside the instruction region
        branch = 1'b1; branch_pc = 32'h0000_1000;
        cyc();
        branch = 1'b0;
        clear_logs();
        repeat (6) cyc();
        chk("reg_no_req", 64'(req_log.size()), 64'd0);
        chk("reg_out_cnt", 64'(out_log.size()), 64'd1);
        chk("reg_out_pc", 64'(out_at(0).pc), 64'h0000_1000);
        chk("reg_out_excp", 64'(out_at(0).excp), 64'b010);

        // bus error on one fetch
        err_addr = 32'h8000_0008;
        flush = 1'b1; flush_pc = 32'h8000_0000;
        cyc();
        flush = 1'b0;
        clear_logs();
        repeat (8) cyc();
        chk("err_out1_pc", 64'(out_at(1).pc), 64'h8000_0004);
        chk("err_out1_excp", 64'(out_at(1).excp), 64'b000);
        chk("err_out2_pc", 64'(out_at(2).pc), 64'h8000_0008);
        chk("err_out2_excp", 64'(out_at(2).excp), 64'b100);
        chk("err_out3_excp", 64'(out_at(3).excp), 64'b000);
        err_addr = 32'hFFFF_FFFF;

        // decoder backpressure
        last_pc = out_at(out_log.size() - 1).pc;
        out_ready = 1'b0;
        clear_logs();
        repeat (5) cyc();
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_out_full", 64'(dut.out_cnt), 64'd2);
        chk("bp_rsp_pending", 64'(rsp_valid), 64'd1);
        chk("bp_rsp_ready", 64'(rsp_ready), 64'd0);
        chk("bp_req_valid", 64'(req_valid), 64'd0);
        out_ready = 1'b1;
        repeat (14) cyc();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("bp_seq_pc%0d", i), 64'(out_at(i).pc), 64'(last_pc + 32'(4 * (i + 1))));
            chk($sformatf("bp_seq_instr%0d", i), 64'(out_at(i).instr),
                64'(data_of(last_pc + 32'(4 * (i + 1)))));
        end

        // reset in the middle of traffic
        rst = 1'b1;
        q.delete(); drive_rsp();
        #1;
        chk("mrst_req_valid", 64'(req_valid), 64'd0);
        chk("mrst_rsp_ready", 64'(rsp_ready), 64'd0);
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_out_pc", 64'(out_pc), 64'd0);
        cyc();
        rst = 1'b0;
        clear_logs();
        repeat (4) cyc();
        chk("mrst_req0", 64'(req_at(0).a), 64'h8000_0000);
        chk("mrst_out0", 64'(out_at(0).pc), 64'h8000_0000);
        chk("mrst_kill", 64'(dut.kill_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
